// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the SRAM port arbiter and its round-robin sub-arbiters.
package sram_port_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 4;
  localparam int unsigned REQ_IDX_W       = $clog2(NUM_REQ_DEFAULT);

  typedef logic [NUM_REQ_DEFAULT-1:0] req_vec_t;
  typedef logic [REQ_IDX_W-1:0]       req_idx_t;

  function automatic req_vec_t idx_to_onehot(input req_idx_t idx);
    req_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered last_grant pointer.
module rr_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant_c
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] win_idx_c;
  logic             win_c;
  int unsigned      cand_c;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_c     = 1'b0;
    win_idx_c = last_grant;
    cand_c    = 0;
    grant_c   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand_c = (32'(last_grant) + off) % NUM_REQ;
      if (!win_c && req[IDX_W'(cand_c)]) begin
        win_c     = 1'b1;
        win_idx_c = IDX_W'(cand_c);
      end
    end
    if (win_c && !reset) grant_c[win_idx_c] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last_grant <= IDX_W'(NUM_REQ - 1);
    else if (win_c) last_grant <= win_idx_c;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a 1W/1R SRAM between NUM_REQ readers and NUM_REQ writers; routes read data back by tag.
// SRAM_ARB_RESP_REG_EN adds a response output register stage (latency 2 instead of 1).
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int unsigned SETS_NUM   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(SETS_NUM)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_grant,
  output logic [NUM_REQ-1:0]            rd_resp_valid,
  output logic [DATA_WIDTH-1:0]         rd_resp_data,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_grant,
  output logic                          sram_read_en,
  output logic [ADDR_WIDTH-1:0]         sram_read_addr,
  input  logic [DATA_WIDTH-1:0]         sram_read_data,
  output logic                          sram_write_en,
  output logic [ADDR_WIDTH-1:0]         sram_write_addr,
  output logic [DATA_WIDTH-1:0]         sram_write_data
);

  logic [NUM_REQ-1:0] resp_tag;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (rd_req),
    .grant_c (rd_grant)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (wr_req),
    .grant_c (wr_grant)
  );

  // Grants are one-hot, so a plain select is enough for the SRAM-side mux.
  always_comb begin
    sram_read_en    = |rd_grant;
    sram_read_addr  = '0;
    sram_write_en   = |wr_grant;
    sram_write_addr = '0;
    sram_write_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rd_grant[i]) sram_read_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (wr_grant[i]) begin
        sram_write_addr = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sram_write_data = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) resp_tag <= '0;
    else       resp_tag <= rd_grant;
  end

`ifdef SRAM_ARB_RESP_REG_EN
  logic [NUM_REQ-1:0]    resp_tag_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_tag_q  <= '0;
      resp_data_q <= '0;
    end else begin
      resp_tag_q  <= resp_tag;
      resp_data_q <= (|resp_tag) ? sram_read_data : '0;
    end
  end

  assign rd_resp_valid = resp_tag_q;
  assign rd_resp_data  = resp_data_q;
`else
  assign rd_resp_valid = resp_tag;
  assign rd_resp_data  = (|resp_tag) ? sram_read_data : '0;
`endif

endmodule
